dfd_axil2apb: RTL and testbench
===============================

DFD_AXIL2APB -- requirements
Module: dfd_axil2apb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 23, AXI/APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; must be a multiple of 32.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS-phase cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports awvalid/awready, awaddr[ADDR_WIDTH], wvalid/wready, wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], bvalid/bready, bresp[2]: AXI4-Lite write channels.
REQ-007 SHALL have ports arvalid/arready, araddr[ADDR_WIDTH], rvalid/rready, rdata[DATA_WIDTH], rresp[2]: AXI4-Lite read channels.
REQ-008 SHALL have APB master outputs paddr[ADDR_WIDTH], psel, penable, pwrite, pwdata[DATA_WIDTH] and pstrb[DATA_WIDTH/8], and inputs pready, prdata[DATA_WIDTH] and pslverr.

Function
REQ-009 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with one transaction outstanding.
REQ-010 SHALL treat a write as eligible in IDLE only when awvalid && wvalid; it SHALL assert awready and wready together, for one cycle only, on the grant.
REQ-011 SHALL assert arready for one cycle in IDLE when a read is granted.
REQ-012 SHALL arbitrate round-robin when write and read are both eligible: grant the type not granted last; after reset the write wins first.
REQ-013 SHALL register address, wdata, wstrb and direction at grant; these SHALL remain stable on the APB bus until the transaction leaves ACCESS.
REQ-014 SHALL drive SETUP in the cycle after grant: psel=1, penable=0.
REQ-015 SHALL drive ACCESS from the following cycle: psel=1, penable=1, held until pready=1 or timeout.
REQ-016 SHALL drive pstrb=wstrb for writes and pstrb=0 for reads.
REQ-017 SHALL ignore pready in SETUP; pready sampled in the first ACCESS cycle completes that transaction.
REQ-018 SHALL, on pready in ACCESS, deassert psel/penable next cycle, capture prdata/pslverr, and enter RESP.
REQ-019 SHALL, in RESP, assert bvalid (write) or rvalid (read) with resp = 2'b10 if pslverr was captured, else 2'b00; rdata SHALL be the captured prdata, held stable while valid.
REQ-020 SHALL hold bvalid/rvalid until bready/rready; the handshake cycle returns the FSM to IDLE, and the next grant occurs no earlier than the following cycle.
REQ-021 SHALL count ACCESS cycles; when the count reaches TIMEOUT_CYCLES without pready, the block SHALL drop psel/penable, enter RESP with resp = 2'b10, and return rdata = 0.
REQ-022 SHALL give a pready that coincides with the timeout cycle precedence over the timeout: the transaction completes normally.
REQ-023 SHALL give minimum latency grant -> response valid of 3 cycles when pready=1 in the first ACCESS cycle.
REQ-024 SHALL not accept lone awvalid or lone wvalid: both ready signals stay low until both valids are present.

Reset
REQ-025 SHALL, while reset is high, force FSM=IDLE, psel=penable=pwrite=0, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, paddr/pwdata/pstrb/rdata=0, timeout count=0, and round-robin pointer=write-first.
REQ-026 SHALL abandon any in-flight transaction asynchronously on reset assertion, without issuing a response; after release, operation SHALL begin in IDLE on the next clk edge.

Structure
REQ-027 SHALL take the FSM state enum and the AXI response codes (OKAY=2'b00, SLVERR=2'b10) from the shared dfd_tr_csr_pkg.
REQ-028 SHALL implement the timeout counter as sub-module dfd_apb_tmo_cnt (inputs clear, count enable; output expired).
REQ-029 SHALL use no FIFOs; total RTL SHALL be no more than 400 lines.

Verification
REQ-030 Single write: awaddr=0x100, wdata=0xDEADBEEF_CAFEF00D, wstrb=0xFF, pready in the first ACCESS cycle -> APB write with the same values, pstrb=0xFF, then bvalid with bresp=00 three cycles after grant.
REQ-031 Read with slave error: araddr=0x200, prdata=0x1234, pslverr=1 -> rvalid with rresp=10 and rdata=0x1234.
REQ-032 Simultaneous write and read requests held for 4 transactions -> grant order W, R, W, R.
REQ-033 Timeout with TIMEOUT_CYCLES=4 and pready held 0 -> psel drops after 4 ACCESS cycles; rresp=10 and rdata=0.
REQ-034 Backpressure: bready low for 5 cycles -> bvalid and bresp stable; a pending arvalid is not granted until the cycle after the bready handshake.
REQ-035 Reset asserted mid-ACCESS -> psel, penable and bvalid reach 0 immediately; a subsequent write completes normally.

Source files
------------

// File: rtl/dfd_tr_csr_pkg.sv
// Shared types for the AXI4-Lite to APB bridge: FSM states and AXI response codes.
package dfd_tr_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  function automatic logic [1:0] axi_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/dfd_apb_tmo_cnt.sv
// ACCESS-phase watchdog: expired rises in the TIMEOUT_CYCLES-th consecutive enabled cycle.
module dfd_apb_tmo_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic cnt_en,
  output logic expired
);

  localparam int          CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [CW-1:0] count;

  // count holds the number of enabled cycles already elapsed, so the limit is one less
  assign expired = (TIMEOUT_CYCLES != 0) && cnt_en && (count == LIMIT[CW-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (cnt_en && !expired && (TIMEOUT_CYCLES != 0)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dfd_axil2apb.sv
// AXI4-Lite slave to APB master bridge, one transaction in flight, round-robin
// between writes and reads, with an optional ACCESS-phase timeout.
module dfd_axil2apb #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);
  import dfd_tr_csr_pkg::*;

  apb_state_e state, state_nxt;
  logic       grant_wr, grant_rd, prio_read, tmo_expired, resp_done;
  logic [1:0] resp_q;

  // prio_read flips to the other type after every grant; readies are masked during reset
  assign grant_wr  = !reset && (state == ST_IDLE) && awvalid && wvalid && (!arvalid || !prio_read);
  assign grant_rd  = !reset && (state == ST_IDLE) && arvalid && (!(awvalid && wvalid) || prio_read);
  assign resp_done = pwrite ? bready : rready;
  assign bresp     = resp_q;
  assign rresp     = resp_q;

  dfd_apb_tmo_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_ACCESS),
    .cnt_en  (state == ST_ACCESS),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant_wr || grant_rd)    state_nxt = ST_SETUP;
      ST_SETUP:                               state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready || tmo_expired)   state_nxt = ST_RESP;
      ST_RESP:   if (resp_done)               state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        awready = grant_wr;
        wready  = grant_wr;
        arready = grant_rd;
      end
      ST_SETUP:  psel = 1'b1;
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      ST_RESP: begin
        bvalid = pwrite;
        rvalid = !pwrite;
      end
      default: ;
    endcase
  end

  // Request fields are captured only at grant, so the APB bus stays stable through ACCESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      rdata     <= '0;
      resp_q    <= AXI_RESP_OKAY;
      prio_read <= 1'b0;
    end else begin
      if (grant_wr || grant_rd) begin
        paddr     <= grant_wr ? awaddr : araddr;
        pwrite    <= grant_wr;
        pwdata    <= wdata;
        pstrb     <= grant_wr ? wstrb : '0;
        prio_read <= grant_wr;
      end
      if (state == ST_ACCESS) begin
        if (pready) begin
          resp_q <= axi_resp(pslverr);
          if (!pwrite) rdata <= prdata;
        end else if (tmo_expired) begin
          resp_q <= AXI_RESP_SLVERR;
          rdata  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dfd_axil2apb.sv
// Self-checking bench for dfd_axil2apb: scripted and randomized AXI traffic against a
// responsive APB slave model, with expectations derived from the bridge's protocol rules.
module tb_dfd_axil2apb;
  localparam int AW  = 23;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0] prdata = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } apb_rec_t;

  apb_rec_t      apb_q[$];
  apb_rec_t      cur;
  int            acc_cnt = 0, last_acc = 0, unstable = 0;
  int            slv_wait = 0;
  bit            slv_never = 1'b0, slv_err = 1'b0;
  logic [DW-1:0] slv_rdata = '0;

  dfd_axil2apb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // APB slave: logs each transfer, answers after slv_wait wait states, and offers pready
  // in SETUP plus junk prdata/pslverr whenever it is not completing.
  initial forever begin
    @(negedge clk);
    if (psel && penable) begin
      acc_cnt++;
      last_acc = acc_cnt;
      if (acc_cnt == 1) begin
        cur = '{paddr, pwrite, pwdata, pstrb};
        apb_q.push_back(cur);
      end else if (paddr !== cur.addr || pwrite !== cur.write || pwdata !== cur.wdata || pstrb !== cur.strb) begin
        unstable++;
      end
      pready  = !slv_never && (acc_cnt == slv_wait + 1);
      prdata  = pready ? slv_rdata : {$urandom, $urandom};
      pslverr = pready ? slv_err : 1'($urandom);
    end else begin
      acc_cnt = 0;
      pready  = psel ? 1'b1 : 1'($urandom);
      prdata  = {$urandom, $urandom};
      pslverr = 1'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output bit ok);
    int n = 0;
    @(negedge clk);
    if (wr) begin
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    end else begin
      arvalid = 1'b1; araddr = a;
    end
    #1;
    while (!(wr ? (awready && wready) : arready) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    ok = (n < 50);
  endtask

  task automatic wait_resp(input bit wr, output logic [1:0] resp, output logic [DW-1:0] rd,
                           output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 50) begin
      @(negedge clk);
      if (lat == 0) begin awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; end
      #1;
      lat++;
      ok = wr ? bvalid : rvalid;
    end
    resp = wr ? bresp : rresp;
    rd   = rdata;
    if (wr) bready = 1'b1; else rready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; awaddr = 'h55; araddr = 'h66;
    #12;
    total++;
    if ({psel, penable, pwrite, awready, wready, arready, bvalid, rvalid} !== 8'h00) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {psel, penable, pwrite, awready, wready, arready, bvalid, rvalid});
    end
    total++;
    if ({bresp, rresp} !== 4'h0) begin
      bad++; $display("FAIL reset_resp: got %b expected 0000", {bresp, rresp});
    end
    total++;
    if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || rdata !== '0) begin
      bad++;
      $display("FAIL reset_data: paddr=%h pwdata=%h pstrb=%h rdata=%h expected all zero",
               paddr, pwdata, pstrb, rdata);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    bit ok, ok2; logic [1:0] resp; logic [DW-1:0] rd; int lat;
    slv_wait = 0; slv_err = 1'b0; slv_never = 1'b0; apb_q.delete();
    start_txn(1'b1, 'h100, 64'hDEADBEEF_CAFEF00D, 8'hFF, ok);
    wait_resp(1'b1, resp, rd, lat, ok2);
    total++;
    if (!(ok && ok2)) begin bad++; $display("FAIL wr_handshake: grant=%0b resp=%0b expected 1 1", ok, ok2); end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    total++;
    if (resp !== 2'b00) begin bad++; $display("FAIL wr_bresp: got %b expected 00", resp); end
    total++;
    if (apb_q.size() != 1 || apb_q[0].addr !== 'h100 || apb_q[0].write !== 1'b1 ||
        apb_q[0].wdata !== 64'hDEADBEEF_CAFEF00D || apb_q[0].strb !== 8'hFF) begin
      bad++;
      $display("FAIL wr_apb: count=%0d got addr=%h wr=%b data=%h strb=%h expected 100/1/deadbeefcafef00d/ff",
               apb_q.size(), cur.addr, cur.write, cur.wdata, cur.strb);
    end
  endtask

  task automatic test_read_slverr();
    bit ok, ok2; logic [1:0] resp; logic [DW-1:0] rd; int lat;
    slv_wait = 0; slv_err = 1'b1; slv_rdata = 64'h1234; apb_q.delete();
    start_txn(1'b0, 'h200, '0, '0, ok);
    wait_resp(1'b0, resp, rd, lat, ok2);
    total++;
    if (!(ok && ok2)) begin bad++; $display("FAIL rd_handshake: grant=%0b resp=%0b expected 1 1", ok, ok2); end
    total++;
    if (resp !== 2'b10) begin bad++; $display("FAIL rd_rresp: got %b expected 10", resp); end
    total++;
    if (rd !== 64'h1234) begin bad++; $display("FAIL rd_rdata: got %h expected 1234", rd); end
    total++;
    if (apb_q.size() != 1 || apb_q[0].addr !== 'h200 || apb_q[0].write !== 1'b0 || apb_q[0].strb !== '0) begin
      bad++;
      $display("FAIL rd_apb: count=%0d got addr=%h wr=%b strb=%h expected 200/0/00",
               apb_q.size(), cur.addr, cur.write, cur.strb);
    end
    slv_err = 1'b0;
  endtask

  task automatic test_lone_valid();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      awvalid = (i < 4); wvalid = (i >= 4); awaddr = 'h44; wdata = 'h99; wstrb = 'h0F;
      #1;
      total++;
      if ({awready, wready, arready, psel} !== 4'b0000) begin
        bad++;
        $display("FAIL lone_valid: cycle %0d got aw/w/ar/psel=%b expected 0000", i,
                 {awready, wready, arready, psel});
      end
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic test_random(input int n_txn);
    bit ok, ok2, wr; logic [1:0] resp, exp_resp; logic [DW-1:0] rd, d; int lat;
    logic [AW-1:0] a; logic [SW-1:0] s;
    unstable = 0;
    for (int i = 0; i < n_txn; i++) begin
      wr = 1'($urandom); a = AW'($urandom); d = {$urandom, $urandom}; s = SW'($urandom);
      slv_wait = $urandom_range(0, 2); slv_err = 1'($urandom); slv_rdata = {$urandom, $urandom};
      slv_never = 1'b0; apb_q.delete();
      exp_resp = slv_err ? 2'b10 : 2'b00;
      start_txn(wr, a, d, s, ok);
      wait_resp(wr, resp, rd, lat, ok2);
      total++;
      if (!(ok && ok2)) begin bad++; $display("FAIL rnd_handshake[%0d]: grant=%0b resp=%0b expected 1 1", i, ok, ok2); end
      total++;
      if (lat != 3 + slv_wait) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, 3 + slv_wait); end
      total++;
      if (resp !== exp_resp) begin bad++; $display("FAIL rnd_resp[%0d]: got %b expected %b", i, resp, exp_resp); end
      if (!wr) begin
        total++;
        if (rd !== slv_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rd, slv_rdata); end
      end
      total++;
      if (apb_q.size() != 1 || apb_q[0].addr !== a || apb_q[0].write !== wr ||
          apb_q[0].strb !== (wr ? s : '0) || (wr && apb_q[0].wdata !== d)) begin
        bad++;
        $display("FAIL rnd_apb[%0d]: count=%0d got addr=%h wr=%b data=%h strb=%h expected %h/%b/%h/%h",
                 i, apb_q.size(), cur.addr, cur.write, cur.wdata, cur.strb, a, wr, d, wr ? s : '0);
      end
    end
    total++;
    if (unstable != 0) begin bad++; $display("FAIL apb_stable: got %0d changes expected 0", unstable); end
  endtask

  task automatic test_timeout();
    bit ok, ok2; logic [1:0] resp; logic [DW-1:0] rd; int lat;
    // pready on the very cycle the timeout would fire: normal completion
    slv_never = 1'b0; slv_wait = TMO - 1; slv_err = 1'b0; slv_rdata = {32'hFEED0000, $urandom | 32'h1};
    start_txn(1'b0, 'h310, '0, '0, ok);
    wait_resp(1'b0, resp, rd, lat, ok2);
    total++;
    if (!(ok && ok2) || last_acc != TMO || lat != 2 + TMO) begin
      bad++; $display("FAIL tmo_edge_timing: acc=%0d lat=%0d expected acc=%0d lat=%0d", last_acc, lat, TMO, 2 + TMO);
    end
    total++;
    if (resp !== 2'b00 || rd !== slv_rdata) begin
      bad++; $display("FAIL tmo_edge_data: got resp=%b rdata=%h expected 00 %h", resp, rd, slv_rdata);
    end
    // slave never answers: bridge gives up after TMO ACCESS cycles
    slv_never = 1'b1;
    start_txn(1'b0, 'h320, '0, '0, ok);
    wait_resp(1'b0, resp, rd, lat, ok2);
    total++;
    if (!(ok && ok2) || last_acc != TMO || lat != 2 + TMO) begin
      bad++; $display("FAIL tmo_timing: acc=%0d lat=%0d expected acc=%0d lat=%0d", last_acc, lat, TMO, 2 + TMO);
    end
    total++;
    if (resp !== 2'b10 || rd !== '0) begin
      bad++; $display("FAIL tmo_data: got resp=%b rdata=%h expected 10 0", resp, rd);
    end
    slv_never = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok, ok2; logic [1:0] resp, exp_resp; logic [DW-1:0] rd, exp_rd; int lat, n;
    slv_wait = 0; slv_err = 1'($urandom); exp_resp = slv_err ? 2'b10 : 2'b00;
    start_txn(1'b1, 'h400, {$urandom, $urandom}, 8'h3C, ok);
    n = 0;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    total++;
    if (!ok || !bvalid) begin bad++; $display("FAIL bp_bvalid: got %b expected 1", bvalid); end
    slv_err = 1'b0; exp_rd = {$urandom, $urandom}; slv_rdata = exp_rd;
    arvalid = 1'b1; araddr = 'h300;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || arready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got bvalid=%b bresp=%b arready=%b expected 1 %b 0", i, bvalid, bresp, arready, exp_resp);
      end
    end
    @(negedge clk); bready = 1'b1; #1;
    total++;
    if (bvalid !== 1'b1 || arready !== 1'b0) begin
      bad++; $display("FAIL bp_handshake: got bvalid=%b arready=%b expected 1 0", bvalid, arready);
    end
    @(negedge clk); bready = 1'b0; #1;
    total++;
    if (arready !== 1'b1 || bvalid !== 1'b0) begin
      bad++; $display("FAIL bp_next_grant: got arready=%b bvalid=%b expected 1 0", arready, bvalid);
    end
    wait_resp(1'b0, resp, rd, lat, ok2);
    total++;
    if (!ok2 || resp !== 2'b00 || rd !== exp_rd || lat != 3) begin
      bad++; $display("FAIL bp_read: got ok=%0b resp=%b rdata=%h lat=%0d expected 1 00 %h 3", ok2, resp, rd, lat, exp_rd);
    end
  endtask

  task automatic test_round_robin();
    string got = "";
    int    n = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    slv_wait = 0; slv_err = 1'b0; slv_never = 1'b0; apb_q.delete();
    bready = 1'b1; rready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 'h500; wdata = 'h1; wstrb = 'h1;
    arvalid = 1'b1; araddr = 'h600;
    while (got.len() < 4 && n < 60) begin
      #1;
      if (awready && arready)       got = {got, "X"};
      else if (awready && wready)   got = {got, "W"};
      else if (arready)             got = {got, "R"};
      @(negedge clk);
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (8) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    total++;
    if (got != "WRWR") begin bad++; $display("FAIL rr_order: got %s expected WRWR", got); end
    total++;
    if (apb_q.size() != 4 || apb_q[0].write !== 1'b1 || apb_q[1].write !== 1'b0 ||
        apb_q[2].write !== 1'b1 || apb_q[3].write !== 1'b0) begin
      bad++; $display("FAIL rr_apb: got %0d transfers expected 4 alternating W/R", apb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2; logic [1:0] resp; logic [DW-1:0] rd, d; int lat, n;
    slv_never = 1'b1;
    start_txn(1'b1, 'h700, 'h77, 'hFF, ok);
    n = 0;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; #1;
    while (!penable && n < 10) begin @(negedge clk); #1; n++; end
    total++;
    if (!ok || penable !== 1'b1) begin bad++; $display("FAIL rst_mid_access: got penable=%b expected 1", penable); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({psel, penable, bvalid} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_async: got psel/penable/bvalid=%b expected 000", {psel, penable, bvalid});
    end
    @(negedge clk); #1;
    total++;
    if ({psel, bvalid, rvalid} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_hold: got psel/bvalid/rvalid=%b expected 000", {psel, bvalid, rvalid});
    end
    @(negedge clk); reset = 1'b0; slv_never = 1'b0; slv_wait = 0; slv_err = 1'b0; apb_q.delete();
    d = {$urandom, $urandom};
    start_txn(1'b1, 'h710, d, 'hA5, ok);
    wait_resp(1'b1, resp, rd, lat, ok2);
    total++;
    if (!(ok && ok2) || resp !== 2'b00 || lat != 3) begin
      bad++; $display("FAIL rst_mid_after: got ok=%0b%0b resp=%b lat=%0d expected 11 00 3", ok, ok2, resp, lat);
    end
    total++;
    if (apb_q.size() != 1 || apb_q[0].addr !== 'h710 || apb_q[0].wdata !== d || apb_q[0].strb !== 'hA5) begin
      bad++; $display("FAIL rst_mid_apb: count=%0d got addr=%h data=%h strb=%h expected 710 %h a5",
                      apb_q.size(), cur.addr, cur.wdata, cur.strb, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_slverr();
    test_lone_valid();
    test_random(40);
    test_timeout();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
